// File: rtl/seq_divider8.sv
// seq_divider8: sequential unsigned restoring divider.
// A start/busy/done handshake launches one division. The divider then runs one
// trial subtraction per cycle, MSB of the dividend first. A zero divisor skips
// the iterations and is flagged in the results.
module seq_divider8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_by_zero_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;        // dividend, shifted out MSB first
    logic [WIDTH-1:0] dsr_q, dsr_d;        // captured divisor
    logic [WIDTH:0]   rem_q, rem_d;        // partial remainder
    logic [WIDTH-1:0] quo_q, quo_d;        // quotient shift register
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic             accept_s;
    logic [WIDTH:0]   r_shift_s;           // remainder with next dividend bit shifted in
    logic [WIDTH+1:0] sum_s;               // R + ~{0,D} + 1 with carry-out on top
    logic             carry_s;             // carry-out set means no borrow
    logic             unused_s;

    assign accept_s  = start_i && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign r_shift_s = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
    assign sum_s     = {1'b0, r_shift_s} + {1'b0, ~{1'b0, dsr_q}} + {{(WIDTH+1){1'b0}}, 1'b1};
    assign carry_s   = sum_s[WIDTH+1];
    // After a restoring step the remainder is below the divisor, so its top bit stays clear.
    assign unused_s  = rem_q[WIDTH];

    // Next-state, datapath and result-register update logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dvd_d       = dvd_q;
        dsr_d       = dsr_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept_s) begin
                    dvd_d = dividend_i;
                    dsr_d = divisor_i;
                    rem_d = {(WIDTH+1){1'b0}};
                    quo_d = {WIDTH{1'b0}};
                    cnt_d = 3'd0;
                    if (divisor_i != {WIDTH{1'b0}}) begin
                        state_d = S_RUN;
                    end else begin
                        // Zero divisor: results are defined directly, no iterations.
                        state_d     = S_DONE;
                        quotient_d  = {WIDTH{1'b1}};
                        remainder_d = dividend_i;
                        dbz_d       = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
                quo_d = {quo_q[WIDTH-2:0], carry_s};
                cnt_d = cnt_q + 3'd1;
                if (carry_s) begin
                    rem_d = sum_s[WIDTH:0];
                end else begin
                    rem_d = r_shift_s;
                end
                if (cnt_q == 3'd7) begin
                    state_d     = S_DONE;
                    quotient_d  = quo_d;
                    remainder_d = rem_d[WIDTH-1:0];
                    dbz_d       = 1'b0;
                end else begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    // State, datapath and registered outputs with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 3'd0;
            dvd_q       <= {WIDTH{1'b0}};
            dsr_q       <= {WIDTH{1'b0}};
            rem_q       <= {(WIDTH+1){1'b0}};
            quo_q       <= {WIDTH{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= {WIDTH{1'b0}};
            remainder_q <= {WIDTH{1'b0}};
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dvd_q       <= dvd_d;
            dsr_q       <= dsr_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign quotient_o    = quotient_q;
    assign remainder_o   = remainder_q;
    assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_seq_divider8.sv
// Directed bench for seq_divider8: hand-computed vectors plus a random
// sample checked against the bench's own division.
module tb_seq_divider8;

    logic       clk;
    logic       rst_n;
    logic       start_i;
    logic [7:0] dividend_i;
    logic [7:0] divisor_i;
    logic       busy_o;
    logic       done_o;
    logic [7:0] quotient_o;
    logic [7:0] remainder_o;
    logic       div_by_zero_o;

    int vectors;
    int miscompares;

    seq_divider8 #(.WIDTH(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start_i),
        .dividend_i    (dividend_i),
        .divisor_i     (divisor_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .quotient_o    (quotient_o),
        .remainder_o   (remainder_o),
        .div_by_zero_o (div_by_zero_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present operands with start for exactly one edge (the accepting edge E).
    task automatic launch(input logic [7:0] a, input logic [7:0] b);
        dividend_i = a;
        divisor_i  = b;
        start_i    = 1'b1;
        tick();
        start_i    = 1'b0;
    endtask

    // Count edges after E until done is seen; bounded. Also counts busy-low cycles before done.
    task automatic wait_done(output int lat, output int busy_low);
        lat = 0;
        busy_low = 0;
        while (done_o !== 1'b1 && lat < 20) begin
            if (busy_o !== 1'b1) busy_low++;
            tick();
            lat++;
        end
    endtask

    // Full division with latency, result and handshake checks.
    task automatic div_case(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input int exp_lat, input logic [7:0] eq, input logic [7:0] er,
                            input logic edz);
        int lat, bl;
        launch(a, b);
        wait_done(lat, bl);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_busy_run"}, bl, 0);
        check({tag, "_q"}, quotient_o, eq);
        check({tag, "_r"}, remainder_o, er);
        check({tag, "_dbz"}, div_by_zero_o, edz);
        check({tag, "_busy_at_done"}, busy_o, 1'b0);
        tick();
        check({tag, "_done_1cyc"}, done_o, 1'b0);
        check({tag, "_q_held"}, quotient_o, eq);
    endtask

    initial begin
        int lat, bl;
        logic [7:0] a, b;
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        start_i     = 1'b0;
        dividend_i  = 8'd0;
        divisor_i   = 8'd0;

        // Reset state
        tick();
        tick();
        check("rst_busy", busy_o, 1'b0);
        check("rst_done", done_o, 1'b0);
        check("rst_q", quotient_o, 8'd0);
        check("rst_r", remainder_o, 8'd0);
        check("rst_dbz", div_by_zero_o, 1'b0);
        rst_n = 1'b1;

        // Basic and boundary operands
        div_case("d100_7", 8'd100, 8'd7, 8, 8'd14, 8'd2, 1'b0);
        div_case("d255_1", 8'd255, 8'd1, 8, 8'd255, 8'd0, 1'b0);
        div_case("d5_9", 8'd5, 8'd9, 8, 8'd0, 8'd5, 1'b0);
        div_case("d255_255", 8'd255, 8'd255, 8, 8'd1, 8'd0, 1'b0);

        // Zero divisor, then a normal division clears the flag
        div_case("d42_0", 8'd42, 8'd0, 0, 8'hFF, 8'd42, 1'b1);
        div_case("d9_3", 8'd9, 8'd3, 8, 8'd3, 8'd0, 1'b0);

        // Start during RUN is ignored
        launch(8'd200, 8'd6);
        tick();
        tick();
        tick();
        dividend_i = 8'd10;
        divisor_i  = 8'd2;
        start_i    = 1'b1;
        tick();
        start_i    = 1'b0;
        check("midrun_busy", busy_o, 1'b1);
        wait_done(lat, bl);
        check("midrun_lat", lat, 4);
        check("midrun_q", quotient_o, 8'd33);
        check("midrun_r", remainder_o, 8'd2);

        // Start accepted in DONE: straight back into RUN, results held meanwhile
        launch(8'd10, 8'd2);
        check("b2b_busy", busy_o, 1'b1);
        check("b2b_done_low", done_o, 1'b0);
        check("b2b_q_held", quotient_o, 8'd33);
        check("b2b_r_held", remainder_o, 8'd2);
        wait_done(lat, bl);
        check("b2b_lat", lat, 8);
        check("b2b_busy_run", bl, 0);
        check("b2b_q", quotient_o, 8'd5);
        check("b2b_r", remainder_o, 8'd0);
        tick();

        // Asynchronous reset in the 4th RUN cycle aborts the operation
        launch(8'd100, 8'd7);
        tick();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy_o, 1'b0);
        check("abort_done", done_o, 1'b0);
        check("abort_q", quotient_o, 8'd0);
        check("abort_r", remainder_o, 8'd0);
        check("abort_dbz", div_by_zero_o, 1'b0);
        tick();
        tick();
        check("abort_no_done", done_o, 1'b0);
        rst_n = 1'b1;
        div_case("d77_8", 8'd77, 8'd8, 8, 8'd9, 8'd5, 1'b0);

        // Random sample of nonzero-divisor pairs against the bench's own division
        for (int i = 0; i < 300; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(1, 255));
            launch(a, b);
            wait_done(lat, bl);
            check("rnd_lat", lat, 8);
            check("rnd_q", quotient_o, a / b);
            check("rnd_r", remainder_o, a % b);
            check("rnd_inv", (32'(quotient_o) * 32'(b)) + 32'(remainder_o), 32'(a));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
